ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Pipeline register between the execute stage and the memory stage of the RV32 core. It captures each EX result beat: ALU result, store data, destination register, memory control and PC. Beats are handed to MEM through a valid/ready handshake, and a two-entry skid buffer keeps EX_READY purely registered. The block also flags misaligned load/store addresses at capture and publishes a forwarding port for the hazard unit.

## Interface
Parameters:
- DATA_WIDTH, 32, width of ALU result and store data
- PC_WIDTH, 32, width of program counter

Ports:
- CLK  in  1  rising-edge clock, the only clock
- RST_N  in  1  reset, asynchronous, active-low
- FLUSH  in  1  synchronous kill of all held and incoming beats
- EX_VALID  in  1  EX presents a beat
- EX_READY  out  1  stage can accept a beat this cycle
- EX_ALU_RESULT  in  DATA_WIDTH  ALU result / effective address
- EX_STORE_DATA  in  DATA_WIDTH  rs2 data for stores
- EX_RD  in  5  destination register
- EX_REG_WRITE  in  1  beat writes RD
- EX_MEM_OP  in  2  00 none, 01 load, 10 store, 11 reserved (treated as none)
- EX_MEM_SIZE  in  2  00 byte, 01 half, 10/11 word
- EX_MEM_UNSIGNED  in  1  zero-extend load
- EX_PC  in  PC_WIDTH  PC of the instruction
- MEM_VALID  out  1  output beat valid
- MEM_READY  in  1  MEM consumes the beat
- MEM_* outputs  out  as inputs  registered copies of every EX_* payload field
- MEM_MISALIGN  out  1  misaligned access flag for the output beat
- FWD_VALID  out  1  forwarding data usable
- FWD_RD  out  5  forwarding destination
- FWD_DATA  out  DATA_WIDTH  forwarding value (MEM_ALU_RESULT)

## Operation
- Two slots, main (drives MEM_*) and skid, each with a valid bit.
- accept = EX_VALID & EX_READY. consume = MEM_VALID & MEM_READY.
- EX_READY = ~skid_valid, taken directly from a flop with no combinational path from MEM_READY.
- Main empty or being consumed, skid empty: an accepted beat loads main.
- Main full and not consumed: an accepted beat loads skid.
- Main consumed while skid full: skid moves to main and skid clears. No accept is possible in that cycle because EX_READY=0.
- Misalign is computed from EX_ALU_RESULT at capture and stored with the beat:
  - it applies only when MEM_OP is load or store
  - half: addr[0]=1 is misaligned
  - word: addr[1:0]≠0 is misaligned
  - byte: never misaligned
- FWD_VALID = MEM_VALID & MEM_REG_WRITE & (MEM_OP≠load) & ~MEM_MISALIGN.
- FWD_RD/FWD_DATA follow the main slot.
- RD=0 with REG_WRITE=1 passes through unchanged, but FWD_VALID is forced 0.
- FLUSH has priority over every other event. At the next edge both valids clear and a beat offered in the same cycle is dropped. Payload registers are not required to clear.

## Timing
- Reset (async assert, sync release by the system): MEM_VALID=0, skid_valid=0, EX_READY=1, FWD_VALID=0, MEM_MISALIGN=0, all payload outputs 0.
- Latency: 1 cycle from accept to MEM_VALID when main is free.
- Throughput: 1 beat/cycle with MEM_READY held high.
- MEM_* are stable while MEM_VALID=1 & MEM_READY=0. Beat order is always preserved.
- One-cycle MEM stall: beat N+1 goes to skid and EX_READY drops the following cycle.
- After MEM_READY returns: skid moves to main, and EX_READY rises one cycle later.
- Reset asserted mid-stall: both slots are discarded immediately.

## Structure
- Shared package: MEM_OP and MEM_SIZE encodings, the misalign function, and register-index width 5.
- One natural sub-module: ex_mem_slot, a payload+valid register with load enable, instantiated twice (main, skid).
- The misalign check lives once, before the skid, so the stored flag travels with the beat.

## Test plan
- Back-to-back stream of ALU beats 0x10..0x1F with MEM_READY=1 -> MEM_VALID high from cycle 1, one beat per cycle in order, EX_READY never drops.
- MEM_READY=0 for 3 cycles during a stream -> skid fills, EX_READY=0 after one cycle, no beat lost or duplicated, order kept.
- Word load at 0x1002, half store at 0x1001, byte load at 0x1003 -> MEM_MISALIGN 1, 1, 0; FWD_VALID=0 for all three.
- ALU beat with RD=5, REG_WRITE=1, result 0xDEADBEEF -> FWD_VALID=1, FWD_RD=5, FWD_DATA=0xDEADBEEF; same beat with RD=0 -> FWD_VALID=0.
- FLUSH while both slots are full and EX_VALID=1 -> next cycle MEM_VALID=0, EX_READY=1, the flushed beats never appear.
- RST_N pulsed low mid-stall -> outputs go to reset values immediately and the stream restarts cleanly after release.

Source files
------------

// File: rtl/ex_mem_stage_pkg.sv
// Shared definitions for the EX/MEM pipeline register: memory-op and
// access-size encodings, register index width and the alignment check.
package ex_mem_stage_pkg;

    localparam int unsigned REG_IDX_W = 5;

    typedef enum logic [1:0] {
        MEM_OP_NONE  = 2'b00,
        MEM_OP_LOAD  = 2'b01,
        MEM_OP_STORE = 2'b10,
        MEM_OP_RSVD  = 2'b11
    } mem_op_e;

    typedef enum logic [1:0] {
        MEM_SZ_BYTE     = 2'b00,
        MEM_SZ_HALF     = 2'b01,
        MEM_SZ_WORD     = 2'b10,
        MEM_SZ_WORD_ALT = 2'b11
    } mem_size_e;

    // Only real loads/stores can be misaligned; reserved op behaves as none.
    function automatic logic is_misaligned(input mem_op_e   op,
                                           input mem_size_e size,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        if (op == MEM_OP_LOAD || op == MEM_OP_STORE) begin
            unique case (size)
                MEM_SZ_BYTE: mis = 1'b0;
                MEM_SZ_HALF: mis = addr_lo[0];
                default:     mis = |addr_lo;
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/ex_mem_slot.sv
// One pipeline slot: a payload register plus its valid bit.
// Priority on the valid bit: flush, then load, then clear.
module ex_mem_slot #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             load_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Next-state for valid bit and payload.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            data_d = data_i;
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
        end else if (clear_i) begin
            valid_d = 1'b0;
        end
    end

    // Slot state register, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX -> MEM pipeline register with a two-entry skid buffer so EX_READY is
// a pure flop output. Misalignment is evaluated once at capture and rides
// with the beat; a forwarding view of the main slot feeds the hazard unit.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PC_WIDTH   = 32
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  FLUSH,
    input  logic                  EX_VALID,
    output logic                  EX_READY,
    input  logic [DATA_WIDTH-1:0] EX_ALU_RESULT,
    input  logic [DATA_WIDTH-1:0] EX_STORE_DATA,
    input  logic [4:0]            EX_RD,
    input  logic                  EX_REG_WRITE,
    input  logic [1:0]            EX_MEM_OP,
    input  logic [1:0]            EX_MEM_SIZE,
    input  logic                  EX_MEM_UNSIGNED,
    input  logic [PC_WIDTH-1:0]   EX_PC,
    output logic                  MEM_VALID,
    input  logic                  MEM_READY,
    output logic [DATA_WIDTH-1:0] MEM_ALU_RESULT,
    output logic [DATA_WIDTH-1:0] MEM_STORE_DATA,
    output logic [4:0]            MEM_RD,
    output logic                  MEM_REG_WRITE,
    output logic [1:0]            MEM_MEM_OP,
    output logic [1:0]            MEM_MEM_SIZE,
    output logic                  MEM_MEM_UNSIGNED,
    output logic [PC_WIDTH-1:0]   MEM_PC,
    output logic                  MEM_MISALIGN,
    output logic                  FWD_VALID,
    output logic [4:0]            FWD_RD,
    output logic [DATA_WIDTH-1:0] FWD_DATA
);

    localparam int unsigned PAY_W = 2 * DATA_WIDTH + REG_IDX_W + 1 + 2 + 2 + 1 + PC_WIDTH + 1;

    logic             ex_mis;
    logic [PAY_W-1:0] ex_pay, main_in, main_pay, skid_pay;
    logic             main_valid, skid_valid;
    logic             accept, consume;
    logic             main_load, skid_load;

    assign ex_mis = is_misaligned(mem_op_e'(EX_MEM_OP), mem_size_e'(EX_MEM_SIZE), EX_ALU_RESULT[1:0]);
    assign ex_pay = {EX_ALU_RESULT, EX_STORE_DATA, EX_RD, EX_REG_WRITE, EX_MEM_OP,
                     EX_MEM_SIZE, EX_MEM_UNSIGNED, EX_PC, ex_mis};

    // Slot steering: a full skid always drains into main before new beats,
    // which keeps order and means EX can never be accepted in that cycle.
    always_comb begin
        accept    = EX_VALID & ~skid_valid;
        consume   = main_valid & MEM_READY;
        main_load = skid_valid ? consume : (accept & (~main_valid | consume));
        skid_load = accept & main_valid & ~consume;
        main_in   = skid_valid ? skid_pay : ex_pay;
    end

    ex_mem_slot #(.WIDTH(PAY_W)) u_main (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .flush_i (FLUSH),
        .load_i  (main_load),
        .clear_i (consume),
        .data_i  (main_in),
        .valid_o (main_valid),
        .data_o  (main_pay)
    );

    ex_mem_slot #(.WIDTH(PAY_W)) u_skid (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .flush_i (FLUSH),
        .load_i  (skid_load),
        .clear_i (consume),
        .data_i  (ex_pay),
        .valid_o (skid_valid),
        .data_o  (skid_pay)
    );

    assign EX_READY  = ~skid_valid;
    assign MEM_VALID = main_valid;
    assign {MEM_ALU_RESULT, MEM_STORE_DATA, MEM_RD, MEM_REG_WRITE, MEM_MEM_OP,
            MEM_MEM_SIZE, MEM_MEM_UNSIGNED, MEM_PC, MEM_MISALIGN} = main_pay;

    assign FWD_VALID = main_valid & MEM_REG_WRITE & (mem_op_e'(MEM_MEM_OP) != MEM_OP_LOAD)
                     & ~MEM_MISALIGN & (MEM_RD != '0);
    assign FWD_RD    = MEM_RD;
    assign FWD_DATA  = MEM_ALU_RESULT;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus random traffic, all
// checked against a queue-based model of a two-deep in-order buffer.
module tb_ex_mem_stage;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [4:0]  rd;
        logic        rw;
        logic [1:0]  op;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] pc;
    } beat_t;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        FLUSH = 1'b0;
    logic        EX_VALID = 1'b0;
    logic        EX_READY;
    logic [31:0] EX_ALU_RESULT = '0;
    logic [31:0] EX_STORE_DATA = '0;
    logic [4:0]  EX_RD = '0;
    logic        EX_REG_WRITE = 1'b0;
    logic [1:0]  EX_MEM_OP = '0;
    logic [1:0]  EX_MEM_SIZE = '0;
    logic        EX_MEM_UNSIGNED = 1'b0;
    logic [31:0] EX_PC = '0;
    logic        MEM_VALID;
    logic        MEM_READY = 1'b0;
    logic [31:0] MEM_ALU_RESULT, MEM_STORE_DATA, MEM_PC, FWD_DATA;
    logic [4:0]  MEM_RD, FWD_RD;
    logic        MEM_REG_WRITE, MEM_MEM_UNSIGNED, MEM_MISALIGN, FWD_VALID;
    logic [1:0]  MEM_MEM_OP, MEM_MEM_SIZE;

    int unsigned total = 0;
    int unsigned bad = 0;
    beat_t       model_q[$];

    ex_mem_stage #(.DATA_WIDTH(32), .PC_WIDTH(32)) dut (
        .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
        .EX_VALID(EX_VALID), .EX_READY(EX_READY),
        .EX_ALU_RESULT(EX_ALU_RESULT), .EX_STORE_DATA(EX_STORE_DATA),
        .EX_RD(EX_RD), .EX_REG_WRITE(EX_REG_WRITE), .EX_MEM_OP(EX_MEM_OP),
        .EX_MEM_SIZE(EX_MEM_SIZE), .EX_MEM_UNSIGNED(EX_MEM_UNSIGNED), .EX_PC(EX_PC),
        .MEM_VALID(MEM_VALID), .MEM_READY(MEM_READY),
        .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_STORE_DATA(MEM_STORE_DATA),
        .MEM_RD(MEM_RD), .MEM_REG_WRITE(MEM_REG_WRITE), .MEM_MEM_OP(MEM_MEM_OP),
        .MEM_MEM_SIZE(MEM_MEM_SIZE), .MEM_MEM_UNSIGNED(MEM_MEM_UNSIGNED), .MEM_PC(MEM_PC),
        .MEM_MISALIGN(MEM_MISALIGN), .FWD_VALID(FWD_VALID), .FWD_RD(FWD_RD),
        .FWD_DATA(FWD_DATA)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Alignment rule: address must be a multiple of the access size in bytes.
    function automatic logic ref_mis(input beat_t b);
        int unsigned nbytes;
        if (b.op != 2'd1 && b.op != 2'd2) return 1'b0;
        nbytes = (b.sz == 2'd0) ? 1 : (b.sz == 2'd1) ? 2 : 4;
        return (b.alu % nbytes) != 0;
    endfunction

    function automatic logic ref_fwd(input beat_t b);
        return b.rw && (b.rd != 5'd0) && (b.op != 2'd1) && !ref_mis(b);
    endfunction

    function automatic beat_t mk(input logic [31:0] alu, input logic [4:0] rd, input logic rw,
                                 input logic [1:0] op, input logic [1:0] sz);
        beat_t b;
        b.alu = alu; b.sd = ~alu; b.rd = rd; b.rw = rw; b.op = op; b.sz = sz;
        b.uns = alu[4]; b.pc = 32'h0000_4000 + {alu[29:0], 2'b00};
        return b;
    endfunction

    function automatic beat_t rand_beat();
        beat_t b;
        b.alu = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom;
        b.sd  = $urandom;
        b.rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        b.rw  = 1'($urandom);
        b.op  = 2'($urandom);
        b.sz  = 2'($urandom);
        b.uns = 1'($urandom);
        b.pc  = $urandom;
        return b;
    endfunction

    task automatic check_outputs();
        beat_t h;
        chk("ex_ready", 32'(EX_READY), 32'(model_q.size() < 2));
        chk("mem_valid", 32'(MEM_VALID), 32'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            h = model_q[0];
            chk("alu", MEM_ALU_RESULT, h.alu);
            chk("store_data", MEM_STORE_DATA, h.sd);
            chk("rd", 32'(MEM_RD), 32'(h.rd));
            chk("reg_write", 32'(MEM_REG_WRITE), 32'(h.rw));
            chk("mem_op", 32'(MEM_MEM_OP), 32'(h.op));
            chk("mem_size", 32'(MEM_MEM_SIZE), 32'(h.sz));
            chk("unsigned", 32'(MEM_MEM_UNSIGNED), 32'(h.uns));
            chk("pc", MEM_PC, h.pc);
            chk("misalign", 32'(MEM_MISALIGN), 32'(ref_mis(h)));
            chk("fwd_valid", 32'(FWD_VALID), 32'(ref_fwd(h)));
            chk("fwd_rd", 32'(FWD_RD), 32'(h.rd));
            chk("fwd_data", FWD_DATA, h.alu);
        end else begin
            chk("fwd_valid_idle", 32'(FWD_VALID), 32'd0);
        end
    endtask

    task automatic check_reset_values();
        chk("rst_mem_valid", 32'(MEM_VALID), 32'd0);
        chk("rst_ex_ready", 32'(EX_READY), 32'd1);
        chk("rst_fwd_valid", 32'(FWD_VALID), 32'd0);
        chk("rst_misalign", 32'(MEM_MISALIGN), 32'd0);
        chk("rst_alu", MEM_ALU_RESULT, 32'd0);
        chk("rst_store_data", MEM_STORE_DATA, 32'd0);
        chk("rst_pc", MEM_PC, 32'd0);
        chk("rst_ctl", {21'd0, MEM_RD, MEM_REG_WRITE, MEM_MEM_OP, MEM_MEM_SIZE, MEM_MEM_UNSIGNED}, 32'd0);
    endtask

    // Drive one cycle of inputs (called at negedge), advance the model over the
    // coming rising edge, then check at the following negedge.
    task automatic cycle(input logic v, input logic r, input logic f, input beat_t b);
        int unsigned n;
        EX_VALID = v; MEM_READY = r; FLUSH = f;
        EX_ALU_RESULT = b.alu; EX_STORE_DATA = b.sd; EX_RD = b.rd; EX_REG_WRITE = b.rw;
        EX_MEM_OP = b.op; EX_MEM_SIZE = b.sz; EX_MEM_UNSIGNED = b.uns; EX_PC = b.pc;
        n = model_q.size();
        if (f) begin
            model_q.delete();
        end else begin
            if (n > 0 && r) void'(model_q.pop_front());
            if (v && n < 2) model_q.push_back(b);
        end
        @(negedge CLK);
        check_outputs();
    endtask

    initial begin
        beat_t b;
        repeat (2) @(negedge CLK);
        check_reset_values();
        RST_N = 1'b1;
        @(negedge CLK);
        check_outputs();

        // Back-to-back stream with MEM always ready.
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 1'b0, mk(32'h10 + 32'(i), 5'd1, 1'b1, 2'd0, 2'd2));
        cycle(1'b0, 1'b1, 1'b0, mk(32'h0, 5'd0, 1'b0, 2'd0, 2'd0));

        // Stream with a three-cycle MEM stall in the middle.
        for (int i = 0; i < 10; i++)
            cycle(1'b1, !(i >= 3 && i < 6), 1'b0, mk(32'h100 + 32'(i), 5'd2, 1'b1, 2'd0, 2'd2));
        repeat (3) cycle(1'b0, 1'b1, 1'b0, mk(32'h0, 5'd0, 1'b0, 2'd0, 2'd0));

        // Alignment boundary cases, one at a time.
        cycle(1'b1, 1'b1, 1'b0, mk(32'h1002, 5'd3, 1'b1, 2'd1, 2'd2));
        chk("word_load_1002_mis", 32'(MEM_MISALIGN), 32'd1);
        chk("word_load_1002_fwd", 32'(FWD_VALID), 32'd0);
        cycle(1'b1, 1'b1, 1'b0, mk(32'h1001, 5'd3, 1'b1, 2'd2, 2'd1));
        chk("half_store_1001_mis", 32'(MEM_MISALIGN), 32'd1);
        chk("half_store_1001_fwd", 32'(FWD_VALID), 32'd0);
        cycle(1'b1, 1'b1, 1'b0, mk(32'h1003, 5'd3, 1'b1, 2'd1, 2'd0));
        chk("byte_load_1003_mis", 32'(MEM_MISALIGN), 32'd0);
        chk("byte_load_1003_fwd", 32'(FWD_VALID), 32'd0);

        // Forwarding with a real destination, then with x0.
        cycle(1'b1, 1'b1, 1'b0, mk(32'hDEADBEEF, 5'd5, 1'b1, 2'd0, 2'd2));
        chk("fwd_rd5_valid", 32'(FWD_VALID), 32'd1);
        chk("fwd_rd5_rd", 32'(FWD_RD), 32'd5);
        chk("fwd_rd5_data", FWD_DATA, 32'hDEADBEEF);
        cycle(1'b1, 1'b1, 1'b0, mk(32'hDEADBEEF, 5'd0, 1'b1, 2'd0, 2'd2));
        chk("fwd_rd0_valid", 32'(FWD_VALID), 32'd0);
        chk("fwd_rd0_rd", 32'(MEM_RD), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, mk(32'h0, 5'd0, 1'b0, 2'd0, 2'd0));

        // Fill both slots, then flush with a beat offered the same cycle.
        cycle(1'b1, 1'b0, 1'b0, mk(32'hA0, 5'd4, 1'b1, 2'd0, 2'd2));
        cycle(1'b1, 1'b0, 1'b0, mk(32'hA1, 5'd4, 1'b1, 2'd0, 2'd2));
        chk("both_full_ready", 32'(EX_READY), 32'd0);
        cycle(1'b1, 1'b0, 1'b1, mk(32'hA2, 5'd4, 1'b1, 2'd0, 2'd2));
        chk("flush_mem_valid", 32'(MEM_VALID), 32'd0);
        chk("flush_ex_ready", 32'(EX_READY), 32'd1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, mk(32'hB0 + 32'(i), 5'd6, 1'b1, 2'd0, 2'd2));
        cycle(1'b0, 1'b1, 1'b0, mk(32'h0, 5'd0, 1'b0, 2'd0, 2'd0));

        // Reset pulse in the middle of a stall.
        cycle(1'b1, 1'b0, 1'b0, mk(32'hC0, 5'd7, 1'b1, 2'd2, 2'd2));
        cycle(1'b1, 1'b0, 1'b0, mk(32'hC1, 5'd7, 1'b1, 2'd2, 2'd2));
        EX_VALID = 1'b0;
        #2 RST_N = 1'b0;
        #1 check_reset_values();
        model_q.delete();
        @(negedge CLK);
        check_reset_values();
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, mk(32'hD0 + 32'(i), 5'd8, 1'b1, 2'd0, 2'd2));

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            b = rand_beat();
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
